// File: rtl/mem_line_ctrl.sv
// Line-to-word bus bridge: turns one 128-bit cache line request into four
// 32-bit bus beats, with per-beat timeout, sticky error flag and line counters.

package mem_line_pkg;

   typedef struct packed {
      logic [31:0]  addr;
      logic [127:0] data;
      logic         rw;
      logic         valid;
   } mem_req_type;

   typedef struct packed {
      logic [127:0] data;
      logic         ready;
   } mem_data_type;

endpackage

module mem_line_ctrl
   import mem_line_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 255
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  mem_req_type  mem_req_i,
   output mem_data_type mem_data_o,
   output logic         bus_req_o,
   output logic         bus_we_o,
   output logic [31:0]  bus_addr_o,
   output logic [31:0]  bus_wdata_o,
   input  logic         bus_ack_i,
   input  logic [31:0]  bus_rdata_i,
   output logic         busy_o,
   output logic         err_o,
   output logic [31:0]  no_rd_line_o,
   output logic [31:0]  no_wr_line_o,
   output logic [1:0]   dbg_state_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam logic [9:0] WAIT_LAST = 10'(MAX_WAIT - 1);

   state_t        state_q, state_d;
   logic [31:0]   base_q, base_d;
   logic [127:0]  wdata_q, wdata_d;
   logic          rw_q, rw_d;
   logic [127:0]  buf_q, buf_d;
   logic [1:0]    beat_q, beat_d;
   logic [9:0]    wait_q, wait_d;
   logic          err_q, err_d;
   logic [31:0]   no_rd_q, no_rd_d;
   logic [31:0]   no_wr_q, no_wr_d;
   logic [6:0]    word_lsb;
   logic          unused_addr_lsbs;

   assign word_lsb         = {beat_q, 5'b0};
   assign unused_addr_lsbs = ^mem_req_i.addr[3:0];

   // Handshake: a line request is taken only when mem_req_i.valid is high in
   // IDLE; mem_data_o.ready pulses for exactly one cycle in RESP. A bus beat
   // completes in any cycle where bus_req_o and bus_ack_i are both high.
   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      wdata_d = wdata_q;
      rw_d    = rw_q;
      buf_d   = buf_q;
      beat_d  = beat_q;
      wait_d  = wait_q;
      err_d   = err_q;
      no_rd_d = no_rd_q;
      no_wr_d = no_wr_q;

      case (state_q)
         IDLE: begin
            if (mem_req_i.valid) begin
               base_d  = {mem_req_i.addr[31:4], 4'b0};
               wdata_d = mem_req_i.data;
               rw_d    = mem_req_i.rw;
               buf_d   = '0;
               beat_d  = 2'd0;
               wait_d  = 10'd0;
               state_d = XFER;
            end
         end
         XFER: begin
            // An ack always beats a timeout falling in the same cycle.
            if (bus_ack_i) begin
               if (!rw_q) begin
                  buf_d[word_lsb +: 32] = bus_rdata_i;
               end
               beat_d = beat_q + 2'd1;
               wait_d = 10'd0;
               if (beat_q == 2'd3) begin
                  state_d = RESP;
               end
            end else if (wait_q == WAIT_LAST) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               wait_d = wait_q + 10'd1;
            end
         end
         RESP: begin
            if (rw_q) begin
               no_wr_d = no_wr_q + 32'd1;
            end else begin
               no_rd_d = no_rd_q + 32'd1;
            end
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         base_q  <= '0;
         wdata_q <= '0;
         rw_q    <= 1'b0;
         buf_q   <= '0;
         beat_q  <= '0;
         wait_q  <= '0;
         err_q   <= 1'b0;
         no_rd_q <= '0;
         no_wr_q <= '0;
      end else begin
         state_q <= state_d;
         base_q  <= base_d;
         wdata_q <= wdata_d;
         rw_q    <= rw_d;
         buf_q   <= buf_d;
         beat_q  <= beat_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         no_rd_q <= no_rd_d;
         no_wr_q <= no_wr_d;
      end
   end

   // Outputs decode straight from registers, so reset clears them at once.
   always_comb begin
      bus_req_o       = 1'b0;
      bus_we_o        = 1'b0;
      bus_addr_o      = '0;
      bus_wdata_o     = '0;
      mem_data_o      = '0;
      if (state_q == XFER) begin
         bus_req_o   = 1'b1;
         bus_we_o    = rw_q;
         bus_addr_o  = base_q + {28'd0, beat_q, 2'b00};
         bus_wdata_o = wdata_q[word_lsb +: 32];
      end
      if (state_q == RESP) begin
         mem_data_o.ready = 1'b1;
         mem_data_o.data  = rw_q ? 128'd0 : buf_q;
      end
   end

   assign busy_o       = (state_q != IDLE);
   assign err_o        = err_q;
   assign no_rd_line_o = no_rd_q;
   assign no_wr_line_o = no_wr_q;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mem_line_ctrl.sv
// Directed bench for mem_line_ctrl: bus responder model, beat/response
// scoreboards, latency and counter checks, timeout and mid-transfer reset.

module tb_mem_line_ctrl;
   import mem_line_pkg::*;

   localparam int MW = 4;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   mem_req_type  mem_req;
   mem_data_type mem_data;
   logic         bus_req, bus_we, bus_ack;
   logic [31:0]  bus_addr, bus_wdata, bus_rdata;
   logic         busy, err;
   logic [31:0]  no_rd, no_wr;
   logic [1:0]   dbg_state;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   mem_line_ctrl #(.MAX_WAIT(MW)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .mem_req_i    (mem_req),
      .mem_data_o   (mem_data),
      .bus_req_o    (bus_req),
      .bus_we_o     (bus_we),
      .bus_addr_o   (bus_addr),
      .bus_wdata_o  (bus_wdata),
      .bus_ack_i    (bus_ack),
      .bus_rdata_i  (bus_rdata),
      .busy_o       (busy),
      .err_o        (err),
      .no_rd_line_o (no_rd),
      .no_wr_line_o (no_wr),
      .dbg_state_o  (dbg_state)
   );

   int            n_cmp = 0;
   int            n_mis = 0;
   logic [64:0]   exp_beat_q[$];
   logic [127:0]  exp_resp_q[$];
   int            rdy_cycs[$];
   int            ack_delay = 0;
   int            drop_beat = -1;
   logic [31:0]   rd_tbl[4];
   int            t_acc = 0;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Bus responder: acks after ack_delay idle cycles, never acks drop_beat.
   initial begin
      int wcnt;
      wcnt = 0;
      bus_ack = 1'b0;
      bus_rdata = '0;
      forever begin
         @(negedge clk);
         if (!bus_req) begin
            bus_ack = 1'b0;
            bus_rdata = '0;
            wcnt = 0;
         end else if (wcnt >= ack_delay && int'(bus_addr[3:2]) != drop_beat) begin
            bus_ack = 1'b1;
            bus_rdata = rd_tbl[bus_addr[3:2]];
            wcnt = 0;
            chk("beat_pending", 128'(exp_beat_q.size() != 0), 128'd1);
            if (exp_beat_q.size() != 0)
               chk("beat", {63'd0, bus_we, bus_addr, bus_wdata}, {63'd0, exp_beat_q.pop_front()});
         end else begin
            bus_ack = 1'b0;
            bus_rdata = '0;
            wcnt++;
         end
      end
   end

   always @(negedge clk) begin
      if (mem_data.ready) begin
         rdy_cycs.push_back(cyc);
         chk("resp_pending", 128'(exp_resp_q.size() != 0), 128'd1);
         if (exp_resp_q.size() != 0)
            chk("resp_data", mem_data.data, exp_resp_q.pop_front());
      end else begin
         chk("data_idle", mem_data.data, 128'd0);
      end
      if (dbg_state != 2'd1)
         chk("bus_idle", {bus_req, bus_we, bus_addr, bus_wdata}, 128'd0);
   end

   task automatic push_line(input logic [31:0] addr, input logic [127:0] data,
                            input logic rw, input int nbeats);
      logic [31:0] base;
      base = {addr[31:4], 4'b0};
      for (int b = 0; b < nbeats; b++)
         exp_beat_q.push_back({rw, base + 32'(4 * b), data[32*b +: 32]});
   endtask

   task automatic issue(input logic [31:0] addr, input logic [127:0] data,
                        input logic rw, input logic hold);
      @(negedge clk);
      mem_req.addr = addr;
      mem_req.data = data;
      mem_req.rw = rw;
      mem_req.valid = 1'b1;
      t_acc = cyc;
      if (!hold) begin
         @(negedge clk);
         mem_req.valid = 1'b0;
      end
   endtask

   task automatic wait_resp(input int n, input string tag);
      for (int i = 0; i < 200 && rdy_cycs.size() < n; i++) @(posedge clk);
      chk(tag, 128'(rdy_cycs.size() >= n), 128'd1);
   endtask

   task automatic run_read(input logic [31:0] addr, input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3, input string tag);
      logic [127:0] d;
      int n0;
      d = {$urandom, $urandom, $urandom, $urandom};
      rd_tbl = '{w0, w1, w2, w3};
      ack_delay = 0;
      drop_beat = -1;
      n0 = rdy_cycs.size();
      push_line(addr, d, 1'b0, 4);
      exp_resp_q.push_back({w3, w2, w1, w0});
      issue(addr, d, 1'b0, 1'b0);
      wait_resp(n0 + 1, {tag, "_ready"});
      if (rdy_cycs.size() > n0) chk({tag, "_lat"}, 128'(rdy_cycs[n0] - t_acc), 128'd5);
      @(negedge clk);
   endtask

   initial begin
      int n0;
      logic [127:0] wd;
      mem_req = '0;
      rd_tbl = '{32'h0, 32'h0, 32'h0, 32'h0};
      #1;
      chk("rst_bus", {bus_req, bus_we, bus_addr, bus_wdata}, 128'd0);
      chk("rst_busy_err", {busy, err, dbg_state}, 128'd0);
      chk("rst_cnt", {no_rd, no_wr}, 128'd0);
      chk("rst_resp", {mem_data.ready, mem_data.data}, 128'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // basic read with zero-wait acks
      run_read(32'h0000_1238, 32'hA0, 32'hA1, 32'hA2, 32'hA3, "rd1");
      chk("rd1_cnt", {no_rd, no_wr}, {32'd1, 32'd0});
      chk("rd1_beats_left", 128'(exp_beat_q.size()), 128'd0);
      chk("rd1_busy", busy, 1'b0);

      // write with three wait cycles per beat (ack lands on the timeout cycle)
      wd = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      ack_delay = 3;
      n0 = rdy_cycs.size();
      push_line(32'h40, wd, 1'b1, 4);
      exp_resp_q.push_back(128'd0);
      issue(32'h40, wd, 1'b1, 1'b0);
      wait_resp(n0 + 1, "wr1_ready");
      if (rdy_cycs.size() > n0) chk("wr1_lat", 128'(rdy_cycs[n0] - t_acc), 128'd17);
      @(negedge clk);
      chk("wr1_cnt", {no_rd, no_wr}, {32'd1, 32'd1});
      chk("wr1_err", err, 1'b0);

      // write-back then allocate with valid held high through RESP
      ack_delay = 0;
      rd_tbl = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
      wd = {$urandom, $urandom, $urandom, $urandom};
      n0 = rdy_cycs.size();
      push_line(32'h80, wd, 1'b1, 4);
      push_line(32'h2004, 128'd0, 1'b0, 4);
      exp_resp_q.push_back(128'd0);
      exp_resp_q.push_back({32'hB3, 32'hB2, 32'hB1, 32'hB0});
      issue(32'h80, wd, 1'b1, 1'b1);
      @(negedge clk);
      mem_req.addr = 32'h2004;
      mem_req.data = 128'd0;
      mem_req.rw = 1'b0;
      for (int i = 0; i < 20 && cyc < t_acc + 7; i++) @(negedge clk);
      mem_req.valid = 1'b0;
      wait_resp(n0 + 2, "wb_ready");
      if (rdy_cycs.size() > n0 + 1) begin
         chk("wb_lat1", 128'(rdy_cycs[n0] - t_acc), 128'd5);
         chk("wb_lat2", 128'(rdy_cycs[n0 + 1] - t_acc), 128'd11);
      end
      repeat (8) @(negedge clk);
      chk("wb_pulses", 128'(rdy_cycs.size() - n0), 128'd2);
      chk("wb_cnt", {no_rd, no_wr}, {32'd2, 32'd2});

      // timeout on beat 1
      ack_delay = 0;
      drop_beat = 1;
      rd_tbl = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
      n0 = rdy_cycs.size();
      push_line(32'h300, 128'd0, 1'b0, 1);
      exp_resp_q.push_back({96'd0, 32'hC0});
      issue(32'h300, 128'd0, 1'b0, 1'b0);
      wait_resp(n0 + 1, "to_ready");
      if (rdy_cycs.size() > n0) chk("to_lat", 128'(rdy_cycs[n0] - t_acc), 128'(2 + MW));
      @(negedge clk);
      chk("to_err", err, 1'b1);
      chk("to_cnt", {no_rd, no_wr}, {32'd3, 32'd2});

      // normal read after a timeout; error flag stays
      run_read(32'h0000_5550, $urandom, $urandom, $urandom, $urandom, "rd2");
      chk("rd2_err_sticky", err, 1'b1);
      chk("rd2_cnt", {no_rd, no_wr}, {32'd4, 32'd2});

      // asynchronous reset during beat 2 of a read
      ack_delay = 2;
      rd_tbl = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
      push_line(32'h600, 128'd0, 1'b0, 4);
      exp_resp_q.push_back({32'hD3, 32'hD2, 32'hD1, 32'hD0});
      issue(32'h600, 128'd0, 1'b0, 1'b0);
      for (int i = 0; i < 50 && !(bus_req && bus_addr[3:2] == 2'd2); i++) @(negedge clk);
      chk("mid_beat2_seen", {bus_req, bus_addr}, {1'b1, 32'h608});
      n0 = rdy_cycs.size();
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_async_bus", {bus_req, bus_we, bus_addr, bus_wdata}, 128'd0);
      chk("mid_async_busy", {busy, dbg_state}, 128'd0);
      exp_beat_q.delete();
      exp_resp_q.delete();
      repeat (3) @(negedge clk);
      chk("mid_cnt", {no_rd, no_wr, 31'd0, err}, 128'd0);
      chk("mid_no_ready", 128'(rdy_cycs.size() - n0), 128'd0);
      rst_n = 1'b1;

      run_read(32'h0000_1238, 32'hA0, 32'hA1, 32'hA2, 32'hA3, "rd3");
      chk("rd3_cnt", {no_rd, no_wr}, {32'd1, 32'd0});
      chk("rd3_err", err, 1'b0);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
